// File: rtl/instr_encoder.sv
// instr_encoder: Y86-64 instruction encoder and instruction-memory byte writer.
// Takes one decoded instruction (icode, ifun, rA, rB, valC) over a valid/ready
// handshake and writes its 1/2/9/10-byte image one byte per accepted write,
// tracking its own write pointer (next PC).
// Optional feature macro: ENC_FORCE_RNONE_EN -- when defined, register nibbles
// the instruction does not use are written as 4'hF (rA of IRMOVQ, rB of PUSHQ/POPQ).

`ifndef SAOK
`define SAOK 3'h1
`endif
`ifndef SHLT
`define SHLT 3'h2
`endif
`ifndef SADR
`define SADR 3'h3
`endif
`ifndef SINS
`define SINS 3'h4
`endif

module instr_encoder #(
    parameter int unsigned MEM_BYTES = 1024
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [3:0]  icode_i,
    input  logic [3:0]  ifun_i,
    input  logic [3:0]  rA_i,
    input  logic [3:0]  rB_i,
    input  logic [63:0] valC_i,
    input  logic        base_load_i,
    input  logic [63:0] base_addr_i,
    output logic        wr_en_o,
    input  logic        wr_ready_i,
    output logic [63:0] wr_addr_o,
    output logic [7:0]  wr_data_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [2:0]  stat_o,
    output logic [63:0] next_pc_o
);

    localparam logic [3:0]  I_HALT   = 4'h0;
    localparam logic [3:0]  I_CMOVQ  = 4'h2;
    localparam logic [3:0]  I_IRMOVQ = 4'h3;
    localparam logic [3:0]  I_RMMOVQ = 4'h4;
    localparam logic [3:0]  I_MRMOVQ = 4'h5;
    localparam logic [3:0]  I_OPQ    = 4'h6;
    localparam logic [3:0]  I_JXX    = 4'h7;
    localparam logic [3:0]  I_CALL   = 4'h8;
    localparam logic [3:0]  I_PUSHQ  = 4'hA;
    localparam logic [3:0]  I_POPQ   = 4'hB;

    localparam logic [64:0] MEM_LIMIT = 65'(MEM_BYTES);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    // Instruction carries a register-specifier byte.
    function automatic logic need_regids(input logic [3:0] icode);
        logic r;
        case (icode)
            I_CMOVQ, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ,
            I_OPQ, I_PUSHQ, I_POPQ: r = 1'b1;
            default:                r = 1'b0;
        endcase
        return r;
    endfunction

    // Instruction carries an 8-byte constant word.
    function automatic logic need_valc(input logic [3:0] icode);
        logic r;
        case (icode)
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ, I_JXX, I_CALL: r = 1'b1;
            default:                                     r = 1'b0;
        endcase
        return r;
    endfunction

    // Byte k of the instruction image; valC is little-endian after the header.
    function automatic logic [7:0] image_byte(
        input logic [3:0]  k,
        input logic [3:0]  icode,
        input logic [3:0]  ifun,
        input logic [3:0]  ra,
        input logic [3:0]  rb,
        input logic [63:0] valc,
        input logic        regids
    );
        logic [2:0] vi;
        logic [7:0] b;
        vi = 3'd0;
        b  = 8'h00;
        if (k == 4'd0) begin
            b = {icode, ifun};
        end else if (regids && (k == 4'd1)) begin
            b = {ra, rb};
        end else begin
            vi = regids ? 3'(k - 4'd2) : 3'(k - 4'd1);
            b  = valc[{vi, 3'b000} +: 8];
        end
        return b;
    endfunction

    state_t      state_r;
    logic [63:0] ptr_r;
    logic [3:0]  idx_r;
    logic [3:0]  len_r;
    logic        last_r;
    logic [3:0]  icode_r;
    logic [3:0]  ifun_r;
    logic [3:0]  ra_r;
    logic [3:0]  rb_r;
    logic [63:0] valc_r;
    logic        regids_r;
    logic        wr_en_r;
    logic [63:0] wr_addr_r;
    logic [7:0]  wr_data_r;
    logic        done_rej_r;
    logic [2:0]  stat_r;

    logic        a_regids_s;
    logic        a_valc_s;
    logic [3:0]  a_len_s;
    logic [64:0] a_end_s;
    logic        oob_s;
    logic        wr_fire_s;
    logic [3:0]  ra_eff_s;
    logic [3:0]  rb_eff_s;

    assign a_regids_s = need_regids(icode_i);
    assign a_valc_s   = need_valc(icode_i);
    assign a_len_s    = 4'd1 + {3'b000, a_regids_s} + {a_valc_s, 3'b000};
    assign a_end_s    = {1'b0, ptr_r} + {61'd0, a_len_s};
    assign oob_s      = (a_end_s > MEM_LIMIT);
    assign wr_fire_s  = wr_en_r && wr_ready_i;

    // Register nibbles as they will appear in the image (optionally forced to none).
    always_comb begin
        ra_eff_s = rA_i;
        rb_eff_s = rB_i;
`ifdef ENC_FORCE_RNONE_EN
        if (icode_i == I_IRMOVQ) begin
            ra_eff_s = 4'hF;
        end else begin
            ra_eff_s = rA_i;
        end
        if ((icode_i == I_PUSHQ) || (icode_i == I_POPQ)) begin
            rb_eff_s = 4'hF;
        end else begin
            rb_eff_s = rB_i;
        end
`endif
    end

    // Encoder FSM: accept/validate in IDLE, stream image bytes in EMIT.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r    <= ST_IDLE;
            ptr_r      <= 64'd0;
            idx_r      <= 4'd0;
            len_r      <= 4'd0;
            last_r     <= 1'b0;
            icode_r    <= 4'd0;
            ifun_r     <= 4'd0;
            ra_r       <= 4'd0;
            rb_r       <= 4'd0;
            valc_r     <= 64'd0;
            regids_r   <= 1'b0;
            wr_en_r    <= 1'b0;
            wr_addr_r  <= 64'd0;
            wr_data_r  <= 8'd0;
            done_rej_r <= 1'b0;
            stat_r     <= `SAOK;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_rej_r <= 1'b0;
                    if (base_load_i) begin
                        ptr_r <= base_addr_i;
                    end else if (req_valid_i) begin
                        if (icode_i > I_POPQ) begin
                            stat_r     <= `SINS;
                            done_rej_r <= 1'b1;
                        end else if (oob_s) begin
                            stat_r     <= `SADR;
                            done_rej_r <= 1'b1;
                        end else begin
                            icode_r   <= icode_i;
                            ifun_r    <= ifun_i;
                            ra_r      <= ra_eff_s;
                            rb_r      <= rb_eff_s;
                            valc_r    <= valC_i;
                            regids_r  <= a_regids_s;
                            len_r     <= a_len_s;
                            idx_r     <= 4'd0;
                            last_r    <= (a_len_s == 4'd1);
                            wr_en_r   <= 1'b1;
                            wr_addr_r <= ptr_r;
                            wr_data_r <= {icode_i, ifun_i};
                            state_r   <= ST_EMIT;
                        end
                    end
                end
                ST_EMIT: begin
                    done_rej_r <= 1'b0;
                    if (wr_fire_s) begin
                        if (last_r) begin
                            ptr_r   <= ptr_r + {60'd0, len_r};
                            stat_r  <= (icode_r == I_HALT) ? `SHLT : `SAOK;
                            wr_en_r <= 1'b0;
                            idx_r   <= 4'd0;
                            last_r  <= 1'b0;
                            state_r <= ST_IDLE;
                        end else begin
                            idx_r     <= idx_r + 4'd1;
                            last_r    <= ((idx_r + 4'd2) == len_r);
                            wr_addr_r <= wr_addr_r + 64'd1;
                            wr_data_r <= image_byte(idx_r + 4'd1, icode_r, ifun_r,
                                                    ra_r, rb_r, valc_r, regids_r);
                        end
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    wr_en_r    <= 1'b0;
                    done_rej_r <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready_o = (state_r == ST_IDLE) && !base_load_i;
    assign busy_o      = (state_r == ST_EMIT);
    assign done_o      = done_rej_r || (wr_fire_s && last_r);
    assign wr_en_o     = wr_en_r;
    assign wr_addr_o   = wr_addr_r;
    assign wr_data_o   = wr_data_r;
    assign stat_o      = stat_r;
    assign next_pc_o   = ptr_r;

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Y86-64 instruction encoder and instruction-memory writer: the inverse of the fetch-stage decode. It accepts one instruction as decoded fields (icode, ifun, rA, rB, valC) over a valid/ready handshake. It serialises the instruction into its variable-length byte image (1, 2, 9 or 10 bytes), one byte per accepted write cycle, into the instruction-memory byte write port. It sits between the program loader/test harness and instruction memory, and maintains its own write pointer (the next PC).

## Interface
Parameters:
- MEM_BYTES, 1024 — instruction memory size in bytes; the writable range is 0..MEM_BYTES-1.

Ports:
- clk_i  in  1  — clock.
- rst_n_i  in  1  — reset; asynchronous, active-low.
- req_valid_i  in  1  — instruction request valid.
- req_ready_o  out  1  — encoder can accept a request.
- icode_i  in  4  — instruction code.
- ifun_i  in  4  — function code.
- rA_i  in  4  — register A.
- rB_i  in  4  — register B.
- valC_i  in  64  — constant word.
- base_load_i  in  1  — load the write pointer from base_addr_i.
- base_addr_i  in  64  — new write-pointer value.
- wr_en_o  out  1  — byte write request.
- wr_ready_i  in  1  — memory accepts the byte this cycle.
- wr_addr_o  out  64  — byte address.
- wr_data_o  out  8  — byte data.
- busy_o  out  1  — emission in progress.
- done_o  out  1  — one-cycle pulse: instruction written or rejected.
- stat_o  out  3  — status of the last request, using the `SAOK/`SHLT/`SADR/`SINS codes from define.v.
- next_pc_o  out  64  — current write pointer.

## Operation
- Length rule:
  - need_regids is set for CMOVQ, IRMOVQ, RMMOVQ, MRMOVQ, OPQ, PUSHQ and POPQ.
  - need_valC is set for IRMOVQ, RMMOVQ, MRMOVQ, JXX and CALL.
  - len = 1 + need_regids + 8·need_valC.
- Byte image, written at consecutive addresses starting at ptr:
  - byte 0 = {icode, ifun}.
  - If need_regids: next byte = {rA, rB}.
  - If need_valC: valC follows, little-endian (valC[7:0] first).
- FSM states: IDLE, EMIT.
  - **IDLE:**
    - req_ready_o = !base_load_i.
    - base_load_i has priority: ptr ← base_addr_i, and no request is accepted that cycle.
    - On accept, the encoder latches the fields and computes len, then checks errors in this order:
      - icode > 4'hB → stat `SINS.
      - ptr + len > MEM_BYTES, compared at 65 bits so the sum cannot wrap → stat `SADR.
    - On error: done_o pulses next cycle, the FSM stays in IDLE, no write is made and ptr is unchanged.
    - Otherwise the FSM goes to EMIT with idx = 0.
  - **EMIT:**
    - wr_en_o = 1, wr_addr_o = ptr + idx, wr_data_o = image[idx].
    - idx advances only on wr_en_o && wr_ready_i.
    - On acceptance of the last byte (idx = len-1):
      - ptr ← ptr + len.
      - done_o pulses the same cycle.
      - stat_o ← `SHLT if icode = HALT, else `SAOK.
      - The FSM returns to IDLE.
    - base_load_i and req_valid_i are ignored in EMIT.
- busy_o = (state == EMIT). Outputs wr_addr_o and wr_data_o are held stable while wr_ready_i is low.
- Reset values:
  - state IDLE, ptr = 0, idx = 0.
  - wr_en_o = 0, wr_addr_o = 0, wr_data_o = 0.
  - busy_o = 0, done_o = 0, stat_o = `SAOK, req_ready_o = 1.
- Reset mid-emission: emission is abandoned immediately, ptr returns to 0, and no further writes are made.

## Timing
- Accept in cycle N (req_valid_i && req_ready_o).
- First write presented in cycle N+1.
- With wr_ready_i held high, the last byte is in N+len, with done_o in N+len.
- Next request is accepted no earlier than N+len+1; throughput is len+1 cycles per instruction.
- A rejected request gives done_o in N+1, and a new request can be accepted in N+1.
- next_pc_o is registered and updates in the cycle after the last byte is accepted.

## Configuration
- Macro: ENC_FORCE_RNONE_EN.
- Defined: unused register nibbles are forced to 4'hF in the image:
  - rA for IRMOVQ.
  - rB for PUSHQ and POPQ.
- Undefined: rA_i and rB_i are written exactly as given.

## Test plan
- **Reset, then IRMOVQ:** reset; irmovq icode 3, ifun 0, rA 1, rB 3, valC 64'h1122334455667788.
  - Without the macro: bytes 30 13 88 77 66 55 44 33 22 11 at addresses 0..9, done_o at the 10th byte, next_pc_o = 10, stat `SAOK.
  - With ENC_FORCE_RNONE_EN: byte 1 = F3.
- **Back-to-back:** RET (icode 9) then OPQ addq %rax,%rbx (icode 6, ifun 0, rA 0, rB 3).
  - Byte 90 at address 10, then bytes 60 03 at addresses 11..12.
  - next_pc_o = 13; the second accept happens no earlier than 2 cycles after the first.
- **Invalid icode:** icode 4'hC → no wr_en_o, done_o in N+1, stat `SINS, next_pc_o unchanged.
- **Bounds:** base_load_i to 1020, then mrmovq (len 10) with MEM_BYTES = 1024 → stat `SADR, no writes.
  - A following HALT at 1020 writes 00 at address 1020 and gives stat `SHLT, next_pc_o = 1021.
- **Backpressure:** call (icode 8) with wr_ready_i low for 3 cycles on byte 2.
  - wr_addr_o and wr_data_o stay stable while stalled; all 9 bytes are written exactly once, in order.
- **Reset mid-emission:** assert rst_n_i low during byte 4 of an IRMOVQ.
  - wr_en_o drops immediately, next_pc_o = 0, req_ready_o = 1 after release.
